// File: rtl/dmem_pkg.sv
// Shared definitions for the multi-port data memory: state encoding,
// byte-to-word address split and the out-of-range check.
package dmem_pkg;

  // Byte address bits below this position select a byte within a word.
  localparam int DMEM_ADDR_LSB = 2;

  typedef enum logic {
    DMEM_INIT  = 1'b0,
    DMEM_READY = 1'b1
  } dmem_state_e;

  // An address is in range when no bit above the word index is set.
  function automatic logic addr_in_range(input logic [31:0] addr,
                                         input int unsigned addr_width);
    logic [31:0] hi;
    hi = addr >> (addr_width + DMEM_ADDR_LSB);
    return (hi == '0);
  endfunction

endpackage

// File: rtl/dmem_rd_port.sv
// One read port of dmem_mp: decodes the request address, checks its range,
// and registers valid/err/data one cycle after the request is accepted.
// With DMEM_PARITY_EN defined, also registers the parity-mismatch flag.
module dmem_rd_port
  import dmem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ready,
  input  logic                  req_valid,
  input  logic [31:0]           req_addr,
  output logic [ADDR_WIDTH-1:0] idx,
  input  logic [DATA_WIDTH-1:0] mem_word,
`ifdef DMEM_PARITY_EN
  input  logic                  mem_perr,
  output logic                  rsp_perr,
`endif
  output logic                  rsp_valid,
  output logic                  rsp_err,
  output logic [DATA_WIDTH-1:0] rsp_data
);

  logic                  accept;
  logic                  in_range;
  logic                  valid_reg;
  logic                  err_reg;
  logic [DATA_WIDTH-1:0] data_reg;

  assign idx      = req_addr[ADDR_WIDTH+1:DMEM_ADDR_LSB];
  assign in_range = addr_in_range(req_addr, ADDR_WIDTH);
  assign accept   = req_valid && ready;

  // Response register: valid pulses once per accept; data holds until the next accept.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_reg <= 1'b0;
      err_reg   <= 1'b0;
      data_reg  <= '0;
    end else begin
      valid_reg <= accept;
      err_reg   <= accept && !in_range;
      if (accept) begin
        data_reg <= in_range ? mem_word : '0;
      end
    end
  end

`ifdef DMEM_PARITY_EN
  logic perr_reg;

  // Parity-mismatch flag travels alongside the response; out-of-range reads never flag it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perr_reg <= 1'b0;
    end else begin
      perr_reg <= accept && in_range && mem_perr;
    end
  end

  assign rsp_perr = perr_reg;
`endif

  assign rsp_valid = valid_reg;
  assign rsp_err   = err_reg;
  assign rsp_data  = data_reg;

endmodule

// File: rtl/dmem_mp.sv
// Multi-read-port data memory with one byte-masked write port.
// After reset a clear sweep zeroes every word before any access is accepted.
// Reads are read-first against a same-cycle write to the same word.
// Optional macro: DMEM_PARITY_EN adds per-lane even parity and the rd_perr output.
module dmem_mp
  import dmem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DATA_SIZE  = 8,
  parameter int ADDR_WIDTH = 10,
  parameter int RAM_DEPTH  = 1024,
  parameter int NUM_RD     = 3,
  localparam int DATA_BYTE = DATA_WIDTH / DATA_SIZE
) (
  input  logic                         clk,
  input  logic                         rst_n,
  output logic                         init_busy,
  input  logic [NUM_RD-1:0]            rd_valid,
  output logic [NUM_RD-1:0]            rd_ready,
  input  logic [NUM_RD*32-1:0]         rd_addr,
  output logic [NUM_RD-1:0]            rd_rsp_valid,
  output logic [NUM_RD-1:0]            rd_rsp_err,
  output logic [NUM_RD*DATA_WIDTH-1:0] rd_rdata,
`ifdef DMEM_PARITY_EN
  output logic [NUM_RD-1:0]            rd_perr,
`endif
  input  logic                         wr_valid,
  output logic                         wr_ready,
  input  logic [DATA_BYTE-1:0]         wr_be,
  input  logic [31:0]                  wr_addr,
  input  logic [DATA_WIDTH-1:0]        wr_data,
  input  logic                         page_fault,
  output logic                         wr_err
);

  localparam logic [ADDR_WIDTH-1:0] CLR_LAST = ADDR_WIDTH'(RAM_DEPTH - 1);

  dmem_state_e           state_reg;
  dmem_state_e           state_next;
  logic [ADDR_WIDTH-1:0] clr_idx_reg;
  logic [ADDR_WIDTH-1:0] clr_idx_next;
  logic                  mem_ready;
  logic                  wr_err_reg;
  logic                  wr_in_range;
  logic                  wr_take;
  logic                  wr_commit;
  logic [ADDR_WIDTH-1:0] wr_idx;

  logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];
`ifdef DMEM_PARITY_EN
  logic [DATA_BYTE-1:0]  par [RAM_DEPTH];
`endif

  // State and clear-index registers; reset restarts the sweep at word 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= DMEM_INIT;
      clr_idx_reg <= '0;
    end else begin
      state_reg   <= state_next;
      clr_idx_reg <= clr_idx_next;
    end
  end

  // Next-state logic: sweep one word per cycle, leave INIT after the last word.
  always_comb begin
    state_next   = state_reg;
    clr_idx_next = clr_idx_reg;
    init_busy    = 1'b0;
    case (state_reg)
      DMEM_INIT: begin
        init_busy    = 1'b1;
        clr_idx_next = clr_idx_reg + 1'b1;
        if (clr_idx_reg == CLR_LAST) begin
          state_next = DMEM_READY;
        end
      end
      DMEM_READY: begin
        state_next = DMEM_READY;
      end
      default: begin
        state_next   = DMEM_INIT;
        clr_idx_next = '0;
      end
    endcase
  end

  assign mem_ready   = (state_reg == DMEM_READY);
  assign rd_ready    = {NUM_RD{mem_ready}};
  assign wr_ready    = mem_ready;

  assign wr_idx      = wr_addr[ADDR_WIDTH+1:DMEM_ADDR_LSB];
  assign wr_in_range = addr_in_range(wr_addr, ADDR_WIDTH);
  assign wr_take     = rst_n && wr_valid && wr_ready;
  assign wr_commit   = wr_take && !page_fault && wr_in_range;

  // Array write: zero fill while sweeping, otherwise byte-masked write of committed requests.
  always_ff @(posedge clk) begin
    if (rst_n && state_reg == DMEM_INIT) begin
      mem[clr_idx_reg] <= '0;
`ifdef DMEM_PARITY_EN
      par[clr_idx_reg] <= '0;
`endif
    end else if (wr_commit) begin
      for (int b = 0; b < DATA_BYTE; b++) begin
        if (wr_be[b]) begin
          mem[wr_idx][b*DATA_SIZE +: DATA_SIZE] <= wr_data[b*DATA_SIZE +: DATA_SIZE];
`ifdef DMEM_PARITY_EN
          par[wr_idx][b] <= ^wr_data[b*DATA_SIZE +: DATA_SIZE];
`endif
        end
      end
    end
  end

  // Write error flag: a taken write that was dropped by page fault or range check.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_err_reg <= 1'b0;
    end else begin
      wr_err_reg <= wr_take && (page_fault || !wr_in_range);
    end
  end

  assign wr_err = wr_err_reg;

  // One independent read port per requester; each reads the array combinationally
  // so a same-cycle write is seen only after the edge (read-first).
  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
    logic [ADDR_WIDTH-1:0] idx;
`ifdef DMEM_PARITY_EN
    logic [DATA_BYTE-1:0]  lane_mis;
    for (genvar bi = 0; bi < DATA_BYTE; bi++) begin : g_lane
      assign lane_mis[bi] = (^mem[idx][bi*DATA_SIZE +: DATA_SIZE]) ^ par[idx][bi];
    end
`endif

    dmem_rd_port #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
    ) u_rd_port (
      .clk       (clk),
      .rst_n     (rst_n),
      .ready     (mem_ready),
      .req_valid (rd_valid[gi]),
      .req_addr  (rd_addr[gi*32 +: 32]),
      .idx       (idx),
      .mem_word  (mem[idx]),
`ifdef DMEM_PARITY_EN
      .mem_perr  (|lane_mis),
      .rsp_perr  (rd_perr[gi]),
`endif
      .rsp_valid (rd_rsp_valid[gi]),
      .rsp_err   (rd_rsp_err[gi]),
      .rsp_data  (rd_rdata[gi*DATA_WIDTH +: DATA_WIDTH])
    );
  end

endmodule

// File: tb/tb_dmem_mp.sv
// Directed bench for dmem_mp with default parameters (32-bit words, 1024 deep, 3 read ports).
module tb_dmem_mp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        init_busy;
  logic [2:0]  rd_valid;
  logic [2:0]  rd_ready;
  logic [95:0] rd_addr;
  logic [2:0]  rd_rsp_valid;
  logic [2:0]  rd_rsp_err;
  logic [95:0] rd_rdata;
`ifdef DMEM_PARITY_EN
  logic [2:0]  rd_perr;
`endif
  logic        wr_valid;
  logic        wr_ready;
  logic [3:0]  wr_be;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        page_fault;
  logic        wr_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_mp dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .init_busy    (init_busy),
    .rd_valid     (rd_valid),
    .rd_ready     (rd_ready),
    .rd_addr      (rd_addr),
    .rd_rsp_valid (rd_rsp_valid),
    .rd_rsp_err   (rd_rsp_err),
    .rd_rdata     (rd_rdata),
`ifdef DMEM_PARITY_EN
    .rd_perr      (rd_perr),
`endif
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_be        (wr_be),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .page_fault   (page_fault),
    .wr_err       (wr_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rdat(input int p);
    return rd_rdata[p*32 +: 32];
  endfunction

  // Present a write at the current negedge; one cycle later wr_err is observable.
  task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] be, input logic pf);
    wr_valid = 1'b1; wr_addr = a; wr_data = d; wr_be = be; page_fault = pf;
    @(negedge clk);
    wr_valid = 1'b0; page_fault = 1'b0;
    $display("write addr=%h data=%h be=%b pf=%0b -> wr_err=%0b", a, d, be, pf, wr_err);
  endtask

  // Present a single-port read; the response is observable at the following negedge.
  task automatic do_read(input int p, input logic [31:0] a);
    rd_valid[p] = 1'b1; rd_addr[p*32 +: 32] = a;
    @(negedge clk);
    rd_valid = '0;
    $display("read port=%0d addr=%h -> valid=%b err=%b data=%h", p, a, rd_rsp_valid, rd_rsp_err, rdat(p));
  endtask

  // Count cycles with init_busy high, also flagging any accept or response seen meanwhile.
  task automatic wait_init(output int cnt, output logic bad);
    cnt = 0;
    bad = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (!init_busy) break;
      cnt++;
      if (rd_ready !== 3'b000 || wr_ready !== 1'b0 || rd_rsp_valid !== 3'b000) bad = 1'b1;
      @(negedge clk);
    end
    $display("init sweep: busy cycles=%0d bad=%0b", cnt, bad);
  endtask

  int   cnt;
  logic bad;

  initial begin
    rst_n = 1'b0; rd_valid = '0; rd_addr = '0;
    wr_valid = 1'b0; wr_be = '0; wr_addr = '0; wr_data = '0; page_fault = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);

    // Values held while reset is asserted
    check("rst_init_busy", init_busy, 1'b1);
    check("rst_rd_ready", rd_ready, 3'b000);
    check("rst_wr_ready", wr_ready, 1'b0);
    check("rst_rsp_valid", rd_rsp_valid, 3'b000);
    check("rst_rsp_err", rd_rsp_err, 3'b000);
    check("rst_rdata0", rdat(0), 32'h0);
    check("rst_wr_err", wr_err, 1'b0);

    // Sweep, with requests pushed throughout that must be ignored
    rst_n = 1'b1;
    rd_valid = 3'b111;
    rd_addr = {32'h0000_0010, 32'h0000_0010, 32'h0000_0010};
    wr_valid = 1'b1; wr_addr = 32'h10; wr_data = 32'hFFFF_FFFF; wr_be = 4'hF;
    wait_init(cnt, bad);
    rd_valid = '0; wr_valid = 1'b0;
    check("init_cycles", cnt, 1024);
    check("init_no_access", bad, 1'b0);
    check("ready_rd", rd_ready, 3'b111);
    check("ready_wr", wr_ready, 1'b1);

    // Zeroed array on all ports
    rd_valid = 3'b111;
    rd_addr = {32'h0000_0200, 32'h0000_03FC, 32'h0000_0000};
    @(negedge clk);
    rd_valid = '0;
    $display("read ports=111 addr=0x0/0x3FC/0x200 -> valid=%b err=%b data=%h", rd_rsp_valid, rd_rsp_err, rd_rdata);
    check("clr_valid", rd_rsp_valid, 3'b111);
    check("clr_err", rd_rsp_err, 3'b000);
    check("clr_0x0", rdat(0), 32'h0);
    check("clr_0x3FC", rdat(1), 32'h0);
    check("clr_0x200", rdat(2), 32'h0);
    do_read(0, 32'h10);
    check("init_write_ignored", rdat(0), 32'h0);

    // Full write then one-lane overwrite
    do_write(32'h10, 32'hDEAD_BEEF, 4'b1111, 1'b0);
    check("wr_full_err", wr_err, 1'b0);
    do_write(32'h10, 32'h0000_00AA, 4'b0001, 1'b0);
    do_write(32'h10, 32'h1111_1111, 4'b0000, 1'b0);
    check("wr_be0_err", wr_err, 1'b0);
    do_read(0, 32'h10);
    check("lane_valid", rd_rsp_valid, 3'b001);
    check("lane_err", rd_rsp_err, 3'b000);
    check("lane_data", rdat(0), 32'hDEAD_BEAA);
    @(negedge clk);
    check("hold_valid", rd_rsp_valid, 3'b000);
    check("hold_data", rdat(0), 32'hDEAD_BEAA);

    // Same-cycle read and write: read-first
    rd_valid[1] = 1'b1; rd_addr[63:32] = 32'h20;
    do_write(32'h20, 32'h1234_5678, 4'b1111, 1'b0);
    check("rf_valid", rd_rsp_valid, 3'b010);
    check("rf_old", rdat(1), 32'h0);
    do_read(1, 32'h20);
    check("rf_new", rdat(1), 32'h1234_5678);

    // Page fault and out-of-range
    do_write(32'h40, 32'hCAFE_F00D, 4'b1111, 1'b1);
    check("pf_wr_err", wr_err, 1'b1);
    do_read(0, 32'h40);
    check("pf_wr_err_clear", wr_err, 1'b0);
    check("pf_data", rdat(0), 32'h0);
    do_write(32'h0000_1010, 32'h5555_5555, 4'b1111, 1'b0);
    check("oor_wr_err", wr_err, 1'b1);
    do_read(2, 32'h0000_1000);
    check("oor_valid", rd_rsp_valid, 3'b100);
    check("oor_err", rd_rsp_err, 3'b100);
    check("oor_data", rdat(2), 32'h0);
    do_read(2, 32'h0000_0010);
    check("oor_alias_untouched", rdat(2), 32'hDEAD_BEAA);

    // Three ports together
    do_write(32'h24, 32'h0BAD_CAFE, 4'b1111, 1'b0);
    rd_valid = 3'b111;
    rd_addr = {32'h0000_0024, 32'h0000_0010, 32'h0000_0010};
    @(negedge clk);
    rd_valid = '0;
    $display("read ports=111 addr=0x10/0x10/0x24 -> valid=%b err=%b data=%h", rd_rsp_valid, rd_rsp_err, rd_rdata);
    check("multi_valid", rd_rsp_valid, 3'b111);
    check("multi_err", rd_rsp_err, 3'b000);
    check("multi_p0", rdat(0), 32'hDEAD_BEAA);
    check("multi_p1", rdat(1), 32'hDEAD_BEAA);
    check("multi_p2", rdat(2), 32'h0BAD_CAFE);

    // Reset while reads are in flight
    rd_valid = 3'b111;
    rd_addr = {32'h0000_0020, 32'h0000_0024, 32'h0000_0010};
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    rd_valid = '0;
    @(negedge clk);
    check("flight_valid", rd_rsp_valid, 3'b111);
    check("flight_busy", init_busy, 1'b0);
    @(negedge clk);
    $display("reset mid-flight -> valid=%b busy=%0b", rd_rsp_valid, init_busy);
    check("mrst_valid", rd_rsp_valid, 3'b000);
    check("mrst_busy", init_busy, 1'b1);
    check("mrst_data", rdat(0), 32'h0);
    rst_n = 1'b1;
    wait_init(cnt, bad);
    check("mrst_init_cycles", cnt, 1024);
    check("mrst_no_access", bad, 1'b0);
    do_read(0, 32'h10);
    check("mrst_cleared_valid", rd_rsp_valid, 3'b001);
    check("mrst_cleared", rdat(0), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_mp.md
Name: dmem_mp

Overview:
- Parametrised successor to the single-cycle 3R1W data memory.
- Provides NUM_RD independent read ports, for example CPU load, PTW level-1 and PTW level-0. Reads are synchronous with a valid/ready handshake; there is one byte-masked write port.
- After reset, a hardware clear sweep zeroes the array before any access is accepted.
- Sits between the LSU/MMU and the core-local RAM space.

Parameters:
- DATA_WIDTH, 32, word width in bits.
- DATA_SIZE, 8, bits per write-mask lane.
- ADDR_WIDTH, 10, word-index width.
- RAM_DEPTH, 1024, number of words; must equal 2**ADDR_WIDTH.
- NUM_RD, 3, number of read ports; range 1..8.
- DATA_BYTE, DATA_WIDTH/DATA_SIZE, number of mask lanes (derived).

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous reset, active-low
- init_busy  out  1  high while the clear sweep runs
- rd_valid  in  NUM_RD  per-port read request
- rd_ready  out  NUM_RD  per-port request accept
- rd_addr  in  NUM_RD*32  byte addresses, port p at [32p+:32]
- rd_rsp_valid  out  NUM_RD  response valid, one cycle after accept
- rd_rsp_err  out  NUM_RD  out-of-range address flag, qualified by rd_rsp_valid
- rd_rdata  out  NUM_RD*DATA_WIDTH  response data
- wr_valid  in  1  write request
- wr_ready  out  1  write accept
- wr_be  in  DATA_BYTE  lane enables
- wr_addr  in  32  byte address
- wr_data  in  DATA_WIDTH  write data
- page_fault  in  1  suppresses the write in the same cycle
- wr_err  out  1  registered; high one cycle after a write dropped for page_fault or out-of-range

Behaviour:
- Word index is addr[ADDR_WIDTH+1:2]; addr[1:0] is ignored.
- An address is out of range if any bit of addr[31:ADDR_WIDTH+2] is set.
- State machine, two states:
  - INIT, entered on reset: counter clr_idx runs 0..RAM_DEPTH-1 and writes zero to mem[clr_idx] each cycle. Moves to READY the cycle after clr_idx == RAM_DEPTH-1.
  - READY: normal operation.
- INIT lasts exactly RAM_DEPTH cycles.
- Values during reset: init_busy=1 and rd_ready=0, wr_ready=0. rd_rsp_valid, rd_rsp_err, rd_rdata and wr_err are all 0.
- rd_ready[p] = wr_ready = (state==READY); the memory never back-pressures otherwise.
- Read handshake, port p: accepted when rd_valid[p] && rd_ready[p].
  - Next cycle: rd_rsp_valid[p]=1 and rd_rdata[p] holds the array word.
  - If the address was out of range, rd_rdata[p]=0 and rd_rsp_err[p]=1.
  - With no accept, rd_rsp_valid[p]=0 and rd_rdata[p] holds its last value.
- Ports are fully independent. Same-address reads on several ports in one cycle all return the same word.
- Write: committed at the clock edge when wr_valid && wr_ready && ~page_fault && in-range.
  - Only lanes with wr_be[i]=1 are updated.
  - wr_be==0 is a legal no-op and does not raise wr_err.
- Read and write to the same word in the same cycle: read-first; the response returns the pre-write data.
- Reset mid-operation: pending responses are discarded, rd_rsp_valid is forced to 0 and the clear sweep restarts at 0.
- Requests presented during INIT are not accepted and produce no response or side effect.

Optional Feature:
- DMEM_PARITY_EN defined:
  - Each lane stores an even-parity bit. Parity is written on a write and zeroed consistently during INIT.
  - Adds output rd_perr (NUM_RD), valid with rd_rsp_valid. It is 1 if any lane of the returned word mismatches its parity.
  - rd_rdata is returned unaltered.
- Undefined: no parity storage and no rd_perr port.

Decomposition:
- Package dmem_pkg holds:
  - the state encoding (DMEM_INIT, DMEM_READY);
  - the range-check helper function;
  - the DMEM_ADDR_LSB=2 constant.
- One natural sub-module, dmem_rd_port: request register, range check, response valid/err/data register. It is instantiated NUM_RD times in a generate loop.
- The array, write logic and init FSM stay in the top level.

Test Plan:
- Reset with RAM_DEPTH=1024 → init_busy=1 for exactly 1024 cycles, rd_ready=0, and every rd_rsp_valid=0 during INIT. Afterwards, a read of 0x0, 0x3FC or 0x200 returns 0.
- Write 0xDEADBEEF to 0x10 with wr_be=4'b1111. Then write 0x000000AA with wr_be=4'b0001. A next-cycle read on port 0 → 0xDEADBEAA one cycle after accept with rd_rsp_err=0.
- Same cycle: write 0x12345678 to 0x20 and read 0x20 on port 1 → response 0x00000000 (read-first). A read of 0x20 one cycle later → 0x12345678.
- Write 0xCAFEF00D to 0x40 with page_fault=1 → wr_err=1 next cycle; a read of 0x40 returns 0. A read of 0x00001000 → rd_rsp_err=1, rd_rdata=0.
- Ports 0, 1 and 2 simultaneously read 0x10, 0x10 and 0x24 → all three rd_rsp_valid=1 in the same cycle, with correct independent data.
- Assert rst_n=0 while reads are in flight → rd_rsp_valid drops to 0, and init_busy rises on the next edge. A previously written 0x10 reads 0 after the new sweep.
